// File: rtl/kt2_issue_if.sv
// kt2_issue_if
//   Bundles the upstream write port, the start/status signals and the
//   operand/result handshake of kt_2 for the kt2_issue operand issuer.
//   master : upstream solver / controller side (drives writes, start, results)
//   slave  : kt2_issue side
//   DEPTH must match the DEPTH of the kt2_issue instance it is connected to.
interface kt2_issue_if #(
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH + 1);

   logic          in_vld;
   logic          in_rdy;
   logic [63:0]   in_psi_i;
   logic [63:0]   in_psi_pow4;
   logic [63:0]   in_alpha_r;
   logic [63:0]   in_psi_r;
   logic          start;
   logic [63:0]   psi_i;
   logic [63:0]   psi_pow4;
   logic [63:0]   alpha_r;
   logic [63:0]   psi_r;
   logic          psipow4_vld;
   logic          alpha_r_vld;
   logic          psi_r_vld;
   logic          kt2_result_vld;
   logic          busy;
   logic          done;
   logic [CW-1:0] issued_cnt;
   logic          err_extra;
   logic          err_timeout;

   modport master (
      output in_vld, in_psi_i, in_psi_pow4, in_alpha_r, in_psi_r, start, kt2_result_vld,
      input  in_rdy, psi_i, psi_pow4, alpha_r, psi_r, psipow4_vld, alpha_r_vld, psi_r_vld,
      input  busy, done, issued_cnt, err_extra, err_timeout
   );

   modport slave (
      input  in_vld, in_psi_i, in_psi_pow4, in_alpha_r, in_psi_r, start, kt2_result_vld,
      output in_rdy, psi_i, psi_pow4, alpha_r, psi_r, psipow4_vld, alpha_r_vld, psi_r_vld,
      output busy, done, issued_cnt, err_extra, err_timeout
   );
endinterface

// File: rtl/kt2_issue.sv
// kt2_issue
//   Operand issuer for kt_2. Buffers operand sets (psi_i, psi_pow4, alpha_r,
//   psi_r) in a FIFO while idle, streams them out on start with all three
//   operand valids aligned in a single cycle, then counts returning result
//   strobes and reports completion, extra results and drain timeout.
// Ports
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : kt2_issue_if.slave (write port, start, operands out, result
//           strobe in, busy/done/issued_cnt/err_extra/err_timeout)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | accept writes; wait for start
// S_ISSUE | pop one set every ISSUE_GAP+1 cycles until FIFO empty
// S_DRAIN | wait for all results or timeout
// S_DONE  | one-cycle done pulse, back to idle
module kt2_issue #(
   parameter int DEPTH     = 16,
   parameter int ISSUE_GAP = 0,
   parameter int TIMEOUT   = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   kt2_issue_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);
   localparam int GW = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;

   logic [255:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [CW-1:0] w_count_nxt;
   logic [CW-1:0] r_issued_cnt;
   logic [CW-1:0] r_ret_cnt;
   logic [GW-1:0] r_gap;
   logic [TW-1:0] r_tmo;

   logic          r_in_rdy;
   logic          r_vld;
   logic          r_busy;
   logic          r_done;
   logic          r_err_extra;
   logic          r_err_timeout;
   logic [255:0]  r_dout;

   logic [255:0]  w_wdata;
   logic [255:0]  w_head;
   logic          w_push;
   logic          w_pop;
   logic          w_empty;
   logic          w_clr;
   logic          w_tmo_hit;
   logic          w_active;
   logic          w_room;
   logic          w_ret_inc;
   logic          w_extra;

   assign w_wdata     = {bus.in_psi_i, bus.in_psi_pow4, bus.in_alpha_r, bus.in_psi_r};
   assign w_push      = bus.in_vld & r_in_rdy;
   assign w_empty     = (r_count == '0);
   // A write landing on an empty FIFO in the same cycle as start is issued
   // straight from the input bus so the first issue still follows start by one cycle.
   assign w_head      = w_empty ? w_wdata : r_mem[r_rd_ptr];
   assign w_active    = (r_state == S_ISSUE) | (r_state == S_DRAIN);
   assign w_room      = (r_ret_cnt != r_issued_cnt);
   assign w_ret_inc   = bus.kt2_result_vld & w_active & w_room;
   assign w_extra     = bus.kt2_result_vld & ((r_state == S_IDLE) | (w_active & ~w_room));
   assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_clr       = 1'b0;
      w_tmo_hit   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_clr = 1'b1;
               if (!w_empty || w_push) begin
                  w_pop       = 1'b1;
                  w_state_nxt = S_ISSUE;
               end else begin
                  w_state_nxt = S_DONE;
               end
            end
         end
         S_ISSUE: begin
            if (w_empty) begin
               w_state_nxt = S_DRAIN;
            end else if (r_gap == '0) begin
               w_pop = 1'b1;
            end
         end
         S_DRAIN: begin
            if ((r_ret_cnt + CW'(w_ret_inc)) == r_issued_cnt) begin
               w_state_nxt = S_DONE;
            end else if (!bus.kt2_result_vld && (r_tmo == TW'(1))) begin
               w_tmo_hit   = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_issued_cnt  <= '0;
         r_ret_cnt     <= '0;
         r_gap         <= '0;
         r_tmo         <= TW'(TIMEOUT);
         r_in_rdy      <= 1'b1;
         r_vld         <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_err_extra   <= 1'b0;
         r_err_timeout <= 1'b0;
         r_dout        <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= w_count_nxt;

         if (w_pop) begin
            r_gap <= GW'(ISSUE_GAP);
         end else if (w_clr) begin
            r_gap <= '0;
         end else if (r_gap != '0) begin
            r_gap <= r_gap - GW'(1);
         end

         // Quiet-cycle down-counter; only runs while draining, reloaded by any result.
         if ((r_state != S_DRAIN) || bus.kt2_result_vld) begin
            r_tmo <= TW'(TIMEOUT);
         end else if (r_tmo != '0) begin
            r_tmo <= r_tmo - TW'(1);
         end

         if (w_clr) begin
            r_issued_cnt <= CW'(w_pop);
            r_ret_cnt    <= '0;
         end else begin
            if (w_pop) begin
               r_issued_cnt <= r_issued_cnt + CW'(1);
            end
            if (w_ret_inc) begin
               r_ret_cnt <= r_ret_cnt + CW'(1);
            end
         end

         r_err_extra   <= w_extra   | (r_err_extra   & ~w_clr);
         r_err_timeout <= w_tmo_hit | (r_err_timeout & ~w_clr);

         r_vld <= w_pop;
         if (w_pop) begin
            r_dout <= w_head;
         end
         r_busy   <= (w_state_nxt == S_ISSUE) | (w_state_nxt == S_DRAIN);
         r_done   <= (w_state_nxt == S_DONE);
         r_in_rdy <= (w_state_nxt == S_IDLE) & (w_count_nxt != CW'(DEPTH));
      end
   end

   assign bus.in_rdy      = r_in_rdy;
   assign bus.psi_i       = r_dout[255:192];
   assign bus.psi_pow4    = r_dout[191:128];
   assign bus.alpha_r     = r_dout[127:64];
   assign bus.psi_r       = r_dout[63:0];
   assign bus.psipow4_vld = r_vld;
   assign bus.alpha_r_vld = r_vld;
   assign bus.psi_r_vld   = r_vld;
   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.issued_cnt  = r_issued_cnt;
   assign bus.err_extra   = r_err_extra;
   assign bus.err_timeout = r_err_timeout;
endmodule
